ts_rx_monitor: RTL and testbench
================================

# ts_rx_monitor

Per-lane training-sequence receive monitor sitting directly upstream of the LTSSM on each lane: it consumes the 128-bit ordered-set stream (`laneN_ts_i` / `laneN_ts_i_vld`) coming from the link partner. It validates and classifies each ordered set as TS1, TS2 or invalid, and latches link/lane numbers and training fields. It counts consecutive matching TS and raises the "N consecutive TS1/TS2 received" qualifiers the LTSSM uses for Polling/Configuration exits. One instance per lane; four per LTSSM.

## Interface
- CNT_TARGET, 8: consecutive-match count that asserts `ts1_rcvd` / `ts2_rcvd`; legal 1..255.
- CNT_W, 8: width of `consec_cnt`; must hold CNT_TARGET.

- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- ts_i  in  128  ordered set; byte k = ts_i[8k+7:8k].
- ts_i_vld  in  1  one ordered set per cycle when high.
- clr  in  1  LTSSM state-change pulse; flushes run history.
- ts1_rcvd  out  1  level: ≥CNT_TARGET consecutive matching TS1.
- ts2_rcvd  out  1  level: ≥CNT_TARGET consecutive matching TS2.
- consec_cnt  out  CNT_W  current run length, saturating at CNT_TARGET.
- link_num  out  8  byte1 of last valid TS.
- lane_num  out  8  byte2 of last valid TS.
- link_pad  out  1  link_num == 8'hF7.
- lane_pad  out  1  lane_num == 8'hF7.
- n_fts  out  8  byte3 of last valid TS.
- train_ctl  out  8  byte5 of last valid TS.
- ts_err  out  1  one-cycle pulse: invalid ordered set received.

## Operation
- TS format: byte0 COM = 8'hBC; bytes1..5 link, lane, N_FTS, rate id, training control; bytes6..15 identifier, all 8'h4A (TS1) or all 8'h45 (TS2).
- Invalid: byte0 ≠ BC, or bytes6..15 not uniformly 4A or 45.
- Match key: {type, bytes1..5}. A valid TS "matches" if its key equals the stored key of the previous valid TS in the current run.
- FSM states: IDLE, RUN_TS1, RUN_TS2.
  - IDLE: valid TS1 → RUN_TS1, cnt=1; valid TS2 → RUN_TS2, cnt=1; invalid → stay, ts_err.
  - RUN_x: matching TS → stay, cnt=min(cnt+1, CNT_TARGET); valid non-matching TS (other type or different fields) → RUN of the new type, cnt=1, key reloaded; invalid → IDLE, cnt=0, ts_err.
  - Any state: clr → IDLE, cnt=0, stored key cleared; latched field outputs retained.
- ts1_rcvd = (state==RUN_TS1) && cnt==CNT_TARGET; ts2_rcvd likewise for RUN_TS2; both registered, mutually exclusive.
- link_num/lane_num/n_fts/train_ctl/pads update on every valid TS (matching or not); unchanged on invalid TS or idle cycles.
- ts_i_vld low: no state or counter change (gaps do not break a run).

## Timing
- All outputs registered; update on the clk edge sampling `ts_i_vld`=1 → visible next cycle (1-cycle latency).
- With back-to-back valid matching TS, ts1_rcvd rises on the cycle after the CNT_TARGET-th TS is sampled.
- ts_err high exactly one cycle per invalid TS; consecutive invalid TS give consecutive pulses.
- clr and ts_i_vld same cycle: clr wins; that TS is discarded (no field update, no ts_err).
- Counter saturates at CNT_TARGET, never wraps; rcvd stays high while matches continue.
- Reset (async assert, any time, including mid-run): state IDLE, consec_cnt 0, ts1_rcvd/ts2_rcvd/ts_err 0, link_num/lane_num 8'hF7, link_pad/lane_pad 1, n_fts 0, train_ctl 0. First TS sampled on the first clk edge after rst deasserts.

## Test plan
- 8 back-to-back TS1 (link F7, lane F7) → consec_cnt 1..8, ts1_rcvd=1 the cycle after the 8th, link_pad=lane_pad=1; a 9th keeps cnt=8.
- 5 TS1 lane=0, then 1 TS1 lane=1, then 8 TS1 lane=1 → cnt resets to 1 at the change, ts1_rcvd only after the 8th lane=1 TS; lane_num=1.
- 8 TS1 then TS2 stream → ts1_rcvd drops the cycle after the first TS2, cnt=1, ts2_rcvd rises after 8 TS2.
- 4 valid TS1, one TS with byte9=8'h45 (mixed identifier), 4 TS1 → ts_err one-cycle pulse, state IDLE, cnt 0 then restarts at 1; no ts1_rcvd.
- TS1 stream with vld gaps of 3 idle cycles between sets → run unbroken, ts1_rcvd after 8 sets; clr asserted coincident with the 6th set → that set dropped, cnt=0, run restarts.
- rst asserted asynchronously after 6 TS2 → immediately cnt=0, ts2_rcvd=0, link_num=lane_num=F7; after release 8 TS2 → ts2_rcvd=1.

Source files
------------

// File: rtl/ts_rx_monitor.sv
// ts_rx_monitor: per-lane training-sequence receive monitor.
// Classifies each 128-bit ordered set as TS1/TS2/invalid, tracks runs of
// identical training sets and raises the N-consecutive qualifiers used by
// the LTSSM for Polling/Configuration exits.
module ts_rx_monitor #(
  parameter int unsigned CNT_TARGET = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     ts_i,
  input  logic             ts_i_vld,
  input  logic             clr,
  output logic             ts1_rcvd,
  output logic             ts2_rcvd,
  output logic [CNT_W-1:0] consec_cnt,
  output logic [7:0]       link_num,
  output logic [7:0]       lane_num,
  output logic             link_pad,
  output logic             lane_pad,
  output logic [7:0]       n_fts,
  output logic [7:0]       train_ctl,
  output logic             ts_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN_TS1 = 2'd1;
  localparam logic [1:0] RUN_TS2 = 2'd2;

  localparam logic [7:0] COM     = 8'hBC;
  localparam logic [7:0] ID_TS1  = 8'h4A;
  localparam logic [7:0] ID_TS2  = 8'h45;
  localparam logic [7:0] PAD     = 8'hF7;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_TARGET);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Match key: {type (0=TS1, 1=TS2), bytes 5..1}
  localparam int unsigned KEY_W = 41;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             ts1_rcvd_q, ts1_rcvd_d;
  logic             ts2_rcvd_q, ts2_rcvd_d;
  logic             ts_err_q, ts_err_d;
  logic [7:0]       link_q, lane_q, nfts_q, tctl_q;
  logic             link_pad_q, lane_pad_q;

  logic             com_ok, all_4a, all_45;
  logic             is_ts1, is_ts2, is_valid;
  logic [KEY_W-1:0] key_in;
  logic             match;
  logic             upd;

  // Ordered-set decode: COM check and uniform identifier over bytes 6..15
  always_comb begin
    com_ok = (ts_i[7:0] == COM);
    all_4a = 1'b1;
    all_45 = 1'b1;
    for (int unsigned k = 6; k < 16; k++) begin
      if (ts_i[8*k +: 8] != ID_TS1) all_4a = 1'b0;
      if (ts_i[8*k +: 8] != ID_TS2) all_45 = 1'b0;
    end
    is_ts1   = com_ok && all_4a;
    is_ts2   = com_ok && all_45;
    is_valid = is_ts1 || is_ts2;
    key_in   = {is_ts2, ts_i[47:8]};
    match    = (state_q != IDLE) && (key_in == key_q);
  end

  // Run-tracking FSM and saturating run counter; clr overrides any sampled set
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    ts_err_d = 1'b0;
    upd      = 1'b0;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      key_d   = '0;
    end else if (ts_i_vld) begin
      if (!is_valid) begin
        ts_err_d = 1'b1;
        state_d  = IDLE;
        cnt_d    = '0;
        key_d    = '0;
      end else begin
        upd = 1'b1;
        if (match) begin
          cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
        end else begin
          state_d = is_ts2 ? RUN_TS2 : RUN_TS1;
          cnt_d   = CNT_ONE;
          key_d   = key_in;
        end
      end
    end
    ts1_rcvd_d = (state_d == RUN_TS1) && (cnt_d == CNT_MAX);
    ts2_rcvd_d = (state_d == RUN_TS2) && (cnt_d == CNT_MAX);
  end

  // FSM, counter, key and qualifier registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      key_q      <= '0;
      ts1_rcvd_q <= 1'b0;
      ts2_rcvd_q <= 1'b0;
      ts_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      ts1_rcvd_q <= ts1_rcvd_d;
      ts2_rcvd_q <= ts2_rcvd_d;
      ts_err_q   <= ts_err_d;
    end
  end

  // Latched training fields, refreshed by every accepted valid TS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_q     <= PAD;
      lane_q     <= PAD;
      link_pad_q <= 1'b1;
      lane_pad_q <= 1'b1;
      nfts_q     <= '0;
      tctl_q     <= '0;
    end else if (upd) begin
      link_q     <= ts_i[15:8];
      lane_q     <= ts_i[23:16];
      link_pad_q <= (ts_i[15:8] == PAD);
      lane_pad_q <= (ts_i[23:16] == PAD);
      nfts_q     <= ts_i[31:24];
      tctl_q     <= ts_i[47:40];
    end
  end

  assign ts1_rcvd   = ts1_rcvd_q;
  assign ts2_rcvd   = ts2_rcvd_q;
  assign consec_cnt = cnt_q;
  assign link_num   = link_q;
  assign lane_num   = lane_q;
  assign link_pad   = link_pad_q;
  assign lane_pad   = lane_pad_q;
  assign n_fts      = nfts_q;
  assign train_ctl  = tctl_q;
  assign ts_err     = ts_err_q;

endmodule

// File: tb/tb_ts_rx_monitor.sv
// Directed testbench for ts_rx_monitor (CNT_TARGET = 8).
module tb_ts_rx_monitor;

  logic         clk;
  logic         rst;
  logic [127:0] ts_i;
  logic         ts_i_vld;
  logic         clr;
  logic         ts1_rcvd, ts2_rcvd;
  logic [7:0]   consec_cnt;
  logic [7:0]   link_num, lane_num, n_fts, train_ctl;
  logic         link_pad, lane_pad, ts_err;

  int unsigned checks;
  int unsigned errors;

  ts_rx_monitor #(
    .CNT_TARGET(8),
    .CNT_W     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ts_i      (ts_i),
    .ts_i_vld  (ts_i_vld),
    .clr       (clr),
    .ts1_rcvd  (ts1_rcvd),
    .ts2_rcvd  (ts2_rcvd),
    .consec_cnt(consec_cnt),
    .link_num  (link_num),
    .lane_num  (lane_num),
    .link_pad  (link_pad),
    .lane_pad  (lane_pad),
    .n_fts     (n_fts),
    .train_ctl (train_ctl),
    .ts_err    (ts_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mk_ts(input logic [7:0] id, input logic [7:0] link,
                                         input logic [7:0] lane, input logic [7:0] nfts,
                                         input logic [7:0] rate, input logic [7:0] tctl);
    logic [127:0] t;
    t = '0;
    t[7:0]   = 8'hBC;
    t[15:8]  = link;
    t[23:16] = lane;
    t[31:24] = nfts;
    t[39:32] = rate;
    t[47:40] = tctl;
    for (int k = 6; k < 16; k++) t[8*k +: 8] = id;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_run(input string tag, input int cnt, input logic r1, input logic r2);
    chk({tag, "_cnt"}, {24'd0, consec_cnt}, cnt);
    chk({tag, "_ts1"}, {31'd0, ts1_rcvd}, {31'd0, r1});
    chk({tag, "_ts2"}, {31'd0, ts2_rcvd}, {31'd0, r2});
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic step(input logic [127:0] t, input logic v, input logic c);
    ts_i     = t;
    ts_i_vld = v;
    clr      = c;
    @(posedge clk);
    #1;
    ts_i_vld = 1'b0;
    clr      = 1'b0;
  endtask

  initial begin
    logic [127:0] t;
    logic [127:0] bad;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    ts_i     = '0;
    ts_i_vld = 1'b0;
    clr      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    chk_run("rst", 0, 1'b0, 1'b0);
    chk("rst_link", {24'd0, link_num}, 32'hF7);
    chk("rst_lane", {24'd0, lane_num}, 32'hF7);
    chk("rst_pads", {30'd0, link_pad, lane_pad}, 32'h3);
    chk("rst_nfts", {24'd0, n_fts}, 32'h0);
    chk("rst_tctl", {24'd0, train_ctl}, 32'h0);
    chk("rst_err", {31'd0, ts_err}, 32'h0);
    rst = 1'b0;

    // 1: nine back-to-back TS1 on PAD link/lane, saturate at 8
    t = mk_ts(8'h4A, 8'hF7, 8'hF7, 8'h10, 8'h02, 8'h00);
    for (int i = 1; i <= 9; i++) begin
      step(t, 1'b1, 1'b0);
      chk_run($sformatf("t1_%0d", i), (i > 8) ? 8 : i, i >= 8, 1'b0);
    end
    chk("t1_pads", {30'd0, link_pad, lane_pad}, 32'h3);
    chk("t1_nfts", {24'd0, n_fts}, 32'h10);
    step('0, 1'b0, 1'b1);
    chk_run("t1_clr", 0, 1'b0, 1'b0);
    chk("t1_clr_link", {24'd0, link_num}, 32'hF7);

    // 2: lane change restarts the run
    t = mk_ts(8'h4A, 8'h00, 8'h00, 8'h10, 8'h02, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      step(t, 1'b1, 1'b0);
      chk_run($sformatf("t2a_%0d", i), i, 1'b0, 1'b0);
    end
    t = mk_ts(8'h4A, 8'h00, 8'h01, 8'h10, 8'h02, 8'h00);
    for (int i = 1; i <= 9; i++) begin
      step(t, 1'b1, 1'b0);
      chk_run($sformatf("t2b_%0d", i), (i > 8) ? 8 : i, i >= 8, 1'b0);
    end
    chk("t2_lane", {24'd0, lane_num}, 32'h1);
    chk("t2_pads", {30'd0, link_pad, lane_pad}, 32'h0);

    // 3: switch to TS2 with identical fields
    t = mk_ts(8'h45, 8'h00, 8'h01, 8'h10, 8'h02, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      step(t, 1'b1, 1'b0);
      chk_run($sformatf("t3_%0d", i), i, 1'b0, i == 8);
    end

    // 4: mixed identifier and bad COM break the run
    step('0, 1'b0, 1'b1);
    chk_run("t4_clr", 0, 1'b0, 1'b0);
    t = mk_ts(8'h4A, 8'h02, 8'h03, 8'h20, 8'h02, 8'h05);
    for (int i = 1; i <= 4; i++) begin
      step(t, 1'b1, 1'b0);
      chk_run($sformatf("t4a_%0d", i), i, 1'b0, 1'b0);
    end
    chk("t4_tctl", {24'd0, train_ctl}, 32'h05);
    bad = mk_ts(8'h4A, 8'h33, 8'h03, 8'h20, 8'h02, 8'h05);
    bad[79:72] = 8'h45;
    step(bad, 1'b1, 1'b0);
    chk("t4_err", {31'd0, ts_err}, 32'h1);
    chk_run("t4_bad", 0, 1'b0, 1'b0);
    chk("t4_link_kept", {24'd0, link_num}, 32'h02);
    step('0, 1'b0, 1'b0);
    chk("t4_err_drop", {31'd0, ts_err}, 32'h0);
    step(bad, 1'b1, 1'b0);
    chk("t4_err2", {31'd0, ts_err}, 32'h1);
    bad = t;
    bad[7:0] = 8'h00;
    step(bad, 1'b1, 1'b0);
    chk("t4_err3", {31'd0, ts_err}, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      step(t, 1'b1, 1'b0);
      chk_run($sformatf("t4b_%0d", i), i, 1'b0, 1'b0);
      chk($sformatf("t4b_err%0d", i), {31'd0, ts_err}, 32'h0);
    end

    // 5: gaps of three idle cycles do not break the run; clr drops a set
    step('0, 1'b0, 1'b1);
    t = mk_ts(8'h4A, 8'h04, 8'h05, 8'h30, 8'h02, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      step(t, 1'b1, 1'b0);
      repeat (3) step('0, 1'b0, 1'b0);
      chk_run($sformatf("t5a_%0d", i), i, i == 8, 1'b0);
    end
    step('0, 1'b0, 1'b1);
    chk_run("t5_clr", 0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(t, 1'b1, 1'b0);
      repeat (3) step('0, 1'b0, 1'b0);
    end
    chk_run("t5b_5", 5, 1'b0, 1'b0);
    step(mk_ts(8'h4A, 8'h04, 8'h09, 8'h30, 8'h02, 8'h00), 1'b1, 1'b1);
    chk_run("t5_drop", 0, 1'b0, 1'b0);
    chk("t5_drop_lane", {24'd0, lane_num}, 32'h05);
    chk("t5_drop_err", {31'd0, ts_err}, 32'h0);
    for (int i = 1; i <= 2; i++) begin
      step(t, 1'b1, 1'b0);
      chk_run($sformatf("t5c_%0d", i), i, 1'b0, 1'b0);
    end

    // 6: asynchronous reset mid-run
    step('0, 1'b0, 1'b1);
    t = mk_ts(8'h45, 8'h06, 8'h07, 8'h40, 8'h02, 8'h08);
    for (int i = 1; i <= 6; i++) step(t, 1'b1, 1'b0);
    chk_run("t6_pre", 6, 1'b0, 1'b0);
    chk("t6_pre_link", {24'd0, link_num}, 32'h06);
    #2 rst = 1'b1;
    #1;
    chk_run("t6_rst", 0, 1'b0, 1'b0);
    chk("t6_rst_link", {24'd0, link_num}, 32'hF7);
    chk("t6_rst_lane", {24'd0, lane_num}, 32'hF7);
    chk("t6_rst_pads", {30'd0, link_pad, lane_pad}, 32'h3);
    chk("t6_rst_tctl", {24'd0, train_ctl}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(t, 1'b1, 1'b0);
      chk_run($sformatf("t6_%0d", i), i, 1'b0, i == 8);
    end
    chk("t6_link", {24'd0, link_num}, 32'h06);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
